// File: rtl/mfp_wdt_reset_req.sv
// Watchdog reset requester: counts down LOAD, raises a PULSE_LEN-cycle soft-reset request on expiry or a bad kick.
// Latency: register reads return one cycle after rd_addr; wdt_rst_req rises on the edge that enters PULSE.
// Backpressure: none; the register port accepts a write every cycle and never stalls.
module mfp_wdt_reset_req #(
  parameter int          PULSE_LEN  = 16,
  parameter logic [31:0] KICK_MAGIC = 32'h5A5A_5A5A,
  parameter logic [31:0] LOAD_RESET = 32'h00FF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        wdt_rst_req,
  output logic        wdt_irq
);

  localparam int PCW = $clog2(PULSE_LEN);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PULSE_LEN - 1);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_KICK   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     load_q, load_d;
  logic [PCW-1:0]  pcnt_q, pcnt_d;
  logic            en_q, en_d;
  logic            irq_en_q, irq_en_d;
  logic            fired_q, fired_d;
  logic            warned_q, warned_d;
  logic            rst_req_d, irq_d;
  logic [31:0]     rd_data_d;

  logic            wr_ctrl, wr_load, wr_kick, wr_stat;
  logic            kick_ok, kick_bad;
  logic            fired_set, warned_set, warned_kick_clr;

  // Decode the write strobe into per-register events.
  always_comb begin
    wr_ctrl  = wr_en && (wr_addr == A_CTRL);
    wr_load  = wr_en && (wr_addr == A_LOAD);
    wr_kick  = wr_en && (wr_addr == A_KICK);
    wr_stat  = wr_en && (wr_addr == A_STATUS);
    kick_ok  = wr_kick && (wr_data == KICK_MAGIC);
    kick_bad = wr_kick && (wr_data != KICK_MAGIC);
  end

  // Next-state logic: kick beats bad kick beats disable beats decrement/expiry.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pcnt_d          = pcnt_q;
    en_d            = en_q;
    irq_en_d        = irq_en_q;
    load_d          = wr_load ? wr_data : load_q;
    fired_set       = 1'b0;
    warned_set      = 1'b0;
    warned_kick_clr = 1'b0;

    if (wr_ctrl) begin
      irq_en_d = wr_data[1];
    end

    case (state_q)
      S_IDLE: begin
        // Kicks are meaningless while stopped; only an enable leaves IDLE.
        if (wr_ctrl) begin
          en_d = wr_data[0];
          if (wr_data[0]) begin
            cnt_d   = load_q;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (kick_ok) begin
          cnt_d           = load_q;
          warned_kick_clr = 1'b1;
        end else if (kick_bad) begin
          state_d = S_PULSE;
          pcnt_d  = '0;
        end else if (wr_ctrl && !wr_data[0]) begin
          // Disable stops the countdown; the counter value is kept.
          en_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (wr_ctrl) begin
            en_d = wr_data[0];
          end
          if (cnt_q == (load_q >> 1)) begin
            warned_set = 1'b1;
          end
          if (cnt_q == 32'd0) begin
            state_d = S_PULSE;
            pcnt_d  = '0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
      end
      S_PULSE: begin
        // Enable writes are ignored here; the pulse always runs to completion.
        if (pcnt_q == PCNT_LAST) begin
          state_d   = S_IDLE;
          fired_set = 1'b1;
          en_d      = 1'b0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status bits: clears first, a same-cycle set event wins.
    fired_d  = (fired_q & ~(wr_stat & wr_data[0])) | fired_set;
    warned_d = (warned_q & ~(wr_stat & wr_data[2]) & ~warned_kick_clr) | warned_set;

    rst_req_d = (state_d == S_PULSE);
    irq_d     = warned_d & irq_en_d;
  end

  // Read mux: reflects register state before any same-cycle write.
  always_comb begin
    rd_data_d = 32'd0;
    case (rd_addr)
      A_CTRL:   rd_data_d = {30'd0, irq_en_q, en_q};
      A_LOAD:   rd_data_d = load_q;
      A_KICK:   rd_data_d = 32'd0;
      A_STATUS: rd_data_d = {29'd0, warned_q, (state_q != S_IDLE), fired_q};
      default:  rd_data_d = 32'd0;
    endcase
  end

  // State and register file; rst is the cold reset so fired survives the soft reset we request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      load_q      <= LOAD_RESET;
      pcnt_q      <= '0;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      fired_q     <= 1'b0;
      warned_q    <= 1'b0;
      rd_data     <= 32'd0;
      wdt_rst_req <= 1'b0;
      wdt_irq     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      pcnt_q      <= pcnt_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      fired_q     <= fired_d;
      warned_q    <= warned_d;
      rd_data     <= rd_data_d;
      wdt_rst_req <= rst_req_d;
      wdt_irq     <= irq_d;
    end
  end

endmodule

// File: tb/tb_mfp_wdt_reset_req.sv
// Bench for mfp_wdt_reset_req: scenario tasks with inline checks; read data goes through a scoreboard queue.
// Latency: inputs change 1 ns after a rising edge, outputs are sampled at the same point.
// Backpressure: none.
module tb_mfp_wdt_reset_req;

  localparam logic [31:0] MAGIC = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic        wdt_rst_req;
  logic        wdt_irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  mfp_wdt_reset_req dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wdt_rst_req (wdt_rst_req),
    .wdt_irq     (wdt_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (wdt_rst_req !== 1'b0 || wdt_irq !== 1'b0 || rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs req=%b irq=%b rd=%h, need 0/0/0", wdt_rst_req, wdt_irq, rd_data);
    end
    rd_addr = 2'd3; sb_q.push_back(32'd0); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL reset_status got=%h need=%h", rd_data, exp_v); end
    rd_addr = 2'd1; sb_q.push_back(32'h00FF_FFFF); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL reset_load got=%h need=%h", rd_data, exp_v); end
    rd_addr = 2'd0; sb_q.push_back(32'd0); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL reset_ctrl got=%h need=%h", rd_data, exp_v); end
  endtask

  task automatic test_expiry();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'd1);
    // Pulse rises 11 edges after COUNT entry.
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_tests++;
      if (wdt_rst_req !== (i == 11)) begin
        n_fail++; $display("FAIL expiry_rise edge=%0d got=%b need=%b", i, wdt_rst_req, (i == 11));
      end
    end
    // Mid-pulse: warned (threshold 5 was passed) and running, not yet fired.
    rd_addr = 2'd3; sb_q.push_back(32'h6); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL expiry_status_mid got=%h need=%h", rd_data, exp_v); end
    wr(2'd3, 32'h4);
    // 13 more high cycles completes 16, then low.
    for (int i = 1; i <= 14; i++) begin
      tick();
      n_tests++;
      if (wdt_rst_req !== (i < 14)) begin
        n_fail++; $display("FAIL expiry_width edge=%0d got=%b need=%b", i, wdt_rst_req, (i < 14));
      end
    end
    rd_addr = 2'd3; sb_q.push_back(32'h1); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL expiry_status got=%h need=%h", rd_data, exp_v); end
    rd_addr = 2'd0; sb_q.push_back(32'h0); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL expiry_ctrl got=%h need=%h", rd_data, exp_v); end
  endtask

  task automatic test_valid_kick();
    logic seen;
    wr(2'd3, 32'h5);
    wr(2'd0, 32'd1);
    seen = 1'b0;
    // Kick every 4 cycles: counter never drops below 7, so neither expiry nor warning.
    for (int k = 0; k < 25; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        if (wdt_rst_req !== 1'b0) seen = 1'b1;
      end
      wr(2'd2, MAGIC);
      if (wdt_rst_req !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL kick_no_pulse got=%b need=0", seen); end
    rd_addr = 2'd3; sb_q.push_back(32'h2); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL kick_status got=%h need=%h", rd_data, exp_v); end
    // Disable returns to IDLE and nothing fires afterwards.
    wr(2'd0, 32'd0);
    rd_addr = 2'd3; sb_q.push_back(32'h0); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL disable_status got=%h need=%h", rd_data, exp_v); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wdt_rst_req !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL disable_no_pulse got=%b need=0", seen); end
  endtask

  task automatic test_kick_at_zero();
    wr(2'd0, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    // Counter is 0 in this cycle; a valid kick wins over expiry.
    wr(2'd2, MAGIC);
    n_tests++;
    if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL kick0_no_pulse got=%b need=0", wdt_rst_req); end
    // Reloaded to 10: pulse 11 edges after the kick.
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_tests++;
      if (wdt_rst_req !== (i == 11)) begin
        n_fail++; $display("FAIL kick0_reload edge=%0d got=%b need=%b", i, wdt_rst_req, (i == 11));
      end
    end
    for (int i = 0; i < 16; i++) tick();
    n_tests++;
    if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL kick0_fall got=%b need=0", wdt_rst_req); end
  endtask

  task automatic test_bad_kick();
    wr(2'd3, 32'h5);
    wr(2'd0, 32'd1);
    tick(); tick(); tick();
    wr(2'd2, 32'h1234_5678);
    n_tests++;
    if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL badkick_rise got=%b need=1", wdt_rst_req); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_tests++;
      if (wdt_rst_req !== (i < 16)) begin
        n_fail++; $display("FAIL badkick_width edge=%0d got=%b need=%b", i, wdt_rst_req, (i < 16));
      end
    end
    rd_addr = 2'd3; sb_q.push_back(32'h1); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL badkick_status got=%h need=%h", rd_data, exp_v); end
  endtask

  task automatic test_load_zero();
    wr(2'd3, 32'h5);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd1);
    n_tests++;
    if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL load0_entry got=%b need=0", wdt_rst_req); end
    tick();
    n_tests++;
    if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL load0_rise got=%b need=1", wdt_rst_req); end
    for (int i = 0; i < 16; i++) tick();
    n_tests++;
    if (wdt_rst_req !== 1'b0) begin n_fail++; $display("FAIL load0_fall got=%b need=0", wdt_rst_req); end
  endtask

  task automatic test_warn_abort();
    wr(2'd3, 32'h5);
    wr(2'd1, 32'd20);
    wr(2'd0, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (wdt_irq !== 1'b0) begin n_fail++; $display("FAIL warn_early got=%b need=0", wdt_irq); end
    tick(); tick();
    n_tests++;
    if (wdt_irq !== 1'b1) begin n_fail++; $display("FAIL warn_irq got=%b need=1", wdt_irq); end
    for (int i = 0; i < 9; i++) tick();
    n_tests++;
    if (wdt_rst_req !== 1'b1) begin n_fail++; $display("FAIL warn_pulse got=%b need=1", wdt_rst_req); end
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (wdt_rst_req !== 1'b0 || wdt_irq !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs req=%b irq=%b need 0/0", wdt_rst_req, wdt_irq);
    end
    rd_addr = 2'd3; sb_q.push_back(32'h0); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL abort_status got=%h need=%h", rd_data, exp_v); end
    rd_addr = 2'd1; sb_q.push_back(32'h00FF_FFFF); tick();
    exp_v = sb_q.pop_front(); n_tests++;
    if (rd_data !== exp_v) begin n_fail++; $display("FAIL abort_load got=%h need=%h", rd_data, exp_v); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_expiry();
    test_valid_kick();
    test_kick_at_zero();
    test_bad_kick();
    test_load_zero();
    test_warn_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
